// File: rtl/bus_responder.sv
// Memory-mapped bus responder: 64-byte window holding an ID word,
// a free-running cycle counter and fourteen scratch registers.
module bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] ID_WORD   = 32'h6583_2B01;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic        strobe_q;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] scratch_q [16];
    logic [31:0] scratch_d [16];
    logic [31:0] rd_val;
    logic        start;
    logic        hit;
    logic        unused_addr;

    assign unused_addr = ^i_bus_addr[1:0];
    assign start = i_bus_clk && !strobe_q;
    assign hit   = i_bus_addr[31:6] == BASE_ADDR[31:6];

    always_comb begin
        unique case (idx_q)
            4'd0:    rd_val = ID_WORD;
            4'd1:    rd_val = cnt_q;
            default: rd_val = scratch_q[idx_q];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        ready_d   = ready_q;
        cnt_d     = cnt_q + 32'd1;
        scratch_d = scratch_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && hit) begin
                    idx_d   = i_bus_addr[5:2];
                    we_d    = i_bus_we;
                    wdata_d = i_bus_data;
                    wait_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_bus_clk) begin
                    state_d = S_IDLE;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_DONE;
                    // Index 0 is read-only; the write is still acked.
                    if (we_q) begin
                        if (idx_q == 4'd1) begin
                            cnt_d = wdata_q;
                        end else if (idx_q >= 4'd2) begin
                            scratch_d[idx_q] = wdata_q;
                        end
                    end else begin
                        data_d = rd_val;
                    end
                end
            end
            S_DONE: begin
                if (!i_bus_clk) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            strobe_q  <= 1'b0;
            wait_q    <= 4'd0;
            idx_q     <= 4'd0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            data_q    <= 32'd0;
            ready_q   <= 1'b0;
            cnt_q     <= 32'd0;
            scratch_q <= '{default: 32'd0};
        end else begin
            state_q   <= state_d;
            strobe_q  <= i_bus_clk;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
        end
    end

    assign o_bus_data       = data_q;
    assign o_bus_data_ready = ready_q;
    assign o_busy           = state_q != S_IDLE;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: directed transactions push
// expected responses, a monitor checks each rising ready.
module tb_bus_responder;

    localparam int WS  = 2;
    localparam int LAT = WS + 2;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;

    typedef struct {
        logic        we;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          errs;
    int          checks;
    logic [31:0] last_rd;

    bus_responder #(
        .BASE_ADDR  (32'h0001_0000),
        .WAIT_STATES(WS)
    ) dut (
        .i_cpu_clk       (clk),
        .i_rst           (rst),
        .i_bus_clk       (strobe),
        .i_bus_we        (we),
        .i_bus_addr      (addr),
        .i_bus_data      (wdata),
        .o_bus_data      (rdata),
        .o_bus_data_ready(ready),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_ready: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    if (!e.we) begin
                        chk("rdata", rdata, e.d);
                        last_rd = e.d;
                    end else begin
                        chk("wr_hold", rdata, last_rd);
                    end
                end
            end
            prev = (ready === 1'b1);
        end
    end

    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        e.we = w;
        e.d  = w ? 32'd0 : d;
        sb.push_back(e);
        we     = w;
        addr   = a;
        wdata  = w ? d : 32'h0BAD_0BAD;
        strobe = 1'b1;
    endtask

    // Scrambles initiator inputs once the start has been taken.
    task automatic await_resp();
        int lat;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                we    = ~we;
                addr  = 32'h0002_0004;
                wdata = ~wdata;
            end
            if (ready === 1'b1) break;
        end
        chk("latency", 32'(lat), 32'(LAT));
    endtask

    task automatic finish_txn();
        strobe = 1'b0;
        @(negedge clk);
        chk("idle_after", {30'd0, ready, busy}, 32'd0);
    endtask

    // Read expects d; write stores d.
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        drive(w, a, d);
        await_resp();
        finish_txn();
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        last_rd = 32'd0;
        rst     = 1'b1;
        strobe  = 1'b0;
        we      = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_data", rdata, 32'd0);
        chk("rst_flags", {30'd0, ready, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 32'h0001_0008, 32'h1234_5678);
        txn(1'b0, 32'h0001_0008, 32'h1234_5678);
        txn(1'b0, 32'h0001_000B, 32'h1234_5678);

        txn(1'b0, 32'h0001_0000, 32'h6583_2B01);
        txn(1'b1, 32'h0001_0000, 32'hFFFF_FFFF);
        txn(1'b0, 32'h0001_0000, 32'h6583_2B01);

        // Counter loaded with FFFF_FFFE; the read commits four edges later.
        txn(1'b1, 32'h0001_0004, 32'hFFFF_FFFE);
        txn(1'b0, 32'h0001_0004, 32'h0000_0002);

        strobe = 1'b1;
        we     = 1'b0;
        addr   = 32'h0002_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("oow_quiet", {30'd0, ready, busy}, 32'd0);
        end
        addr = 32'h0001_0008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_no_restart", {30'd0, ready, busy}, 32'd0);
        end
        strobe = 1'b0;
        @(negedge clk);

        txn(1'b1, 32'h0001_000C, 32'h5555_0003);
        we     = 1'b1;
        addr   = 32'h0001_000C;
        wdata  = 32'hAAAA_AAAA;
        strobe = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        strobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_ready", {31'd0, ready}, 32'd0);
        end
        chk("abort_idle", {31'd0, busy}, 32'd0);
        txn(1'b0, 32'h0001_000C, 32'h5555_0003);

        drive(1'b1, 32'h0001_0008, 32'hCAFE_F00D);
        await_resp();
        #2;
        rst     = 1'b1;
        last_rd = 32'd0;
        #1;
        chk("rst_ready_drop", {31'd0, ready}, 32'd0);
        chk("rst_busy_drop", {31'd0, busy}, 32'd0);
        chk("rst_data_clr", rdata, 32'd0);
        drive(1'b0, 32'h0001_0008, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        await_resp();
        finish_txn();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
